// File: rtl/systolic_result_drain_if.sv
// Output stream of the systolic result drain: one quantized element per
// handshake, with its matrix coordinates and status sideband.
interface systolic_result_drain_if #(
  parameter int OUT_WIDTH = 16
);
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_row;
  logic [7:0]           out_col;
  logic                 out_last;
  logic                 out_sat;

  modport master (
    output out_data, out_valid, out_row, out_col, out_last, out_sat,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_row, out_col, out_last, out_sat,
    output out_ready
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Captures the systolic array's accumulator matrix on a result pulse and drains
// it row-major as rounded, saturated fixed-point elements over valid/ready.
module systolic_result_drain #(
  parameter int ARRAY_SIZE  = 4,
  parameter int ACCUM_WIDTH = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int FRAC_SHIFT  = 6
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [ACCUM_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] result_flat,
  input  logic                                         result_valid,
  systolic_result_drain_if.master                      stream,
  output logic                                         busy,
  output logic                                         overflow_err,
  input  logic                                         clear_err
);

  localparam int BANK_W = ACCUM_WIDTH * ARRAY_SIZE * ARRAY_SIZE;
  localparam logic [7:0] LAST_IDX = 8'(ARRAY_SIZE - 1);

  // Half an output LSB in accumulator units; zero when no shift is applied.
  localparam logic signed [ACCUM_WIDTH:0] RND =
    ((ACCUM_WIDTH+1)'(1) << FRAC_SHIFT) >> 1;
  localparam logic signed [ACCUM_WIDTH:0] SAT_MAX =
    {{(ACCUM_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACCUM_WIDTH:0] SAT_MIN =
    {{(ACCUM_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  state_e                         state_q, state_d;
  logic [BANK_W-1:0]              bank_q;
  logic [7:0]                     row_q, col_q;
  logic                           at_last;
  logic                           valid;
  logic                           capture;
  logic                           drop;
  logic [15:0]                    elem_idx;
  logic signed [ACCUM_WIDTH-1:0]  elem;
  logic signed [ACCUM_WIDTH:0]    ext;
  logic signed [ACCUM_WIDTH:0]    rounded;
  logic signed [ACCUM_WIDTH:0]    shifted;
  logic [OUT_WIDTH-1:0]           q_data;
  logic                           q_sat;

  assign at_last = (row_q == LAST_IDX) && (col_q == LAST_IDX);

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    valid   = 1'b0;
    capture = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (result_valid) begin
          capture = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        valid = 1'b1;
        if (stream.out_ready && at_last) begin
          // A pulse on the final handshake chains straight into the next matrix.
          if (result_valid) capture = 1'b1;
          else              state_d = IDLE;
        end else if (result_valid) begin
          drop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the capture bank is reset on purpose: out_data must read 0 out of
  // reset, and a mid-stream reset discards the held matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else if (capture) begin
      bank_q <= result_flat;
      row_q  <= '0;
      col_q  <= '0;
    end else if (valid && stream.out_ready) begin
      if (at_last) begin
        row_q <= '0;
        col_q <= '0;
      end else if (col_q == LAST_IDX) begin
        row_q <= row_q + 8'd1;
        col_q <= '0;
      end else begin
        col_q <= col_q + 8'd1;
      end
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         overflow_err <= 1'b0;
    else if (drop)      overflow_err <= 1'b1;
    else if (clear_err) overflow_err <= 1'b0;
  end

  assign elem_idx = 16'(row_q) * 16'(ARRAY_SIZE) + 16'(col_q);
  assign elem     = bank_q[32'(elem_idx)*ACCUM_WIDTH +: ACCUM_WIDTH];
  assign ext      = {elem[ACCUM_WIDTH-1], elem};
  assign rounded  = ext + RND;
  assign shifted  = rounded >>> FRAC_SHIFT;

  always_comb begin
    q_data = shifted[OUT_WIDTH-1:0];
    q_sat  = 1'b0;
    if (shifted > SAT_MAX) begin
      q_data = SAT_MAX[OUT_WIDTH-1:0];
      q_sat  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      q_data = SAT_MIN[OUT_WIDTH-1:0];
      q_sat  = 1'b1;
    end
  end

  assign stream.out_valid = valid;
  assign stream.out_data  = q_data;
  assign stream.out_sat   = q_sat;
  assign stream.out_row   = row_q;
  assign stream.out_col   = col_q;
  assign stream.out_last  = valid && at_last;
  assign busy             = valid;

endmodule
